// File: rtl/time_keeper.sv
// 24-hour BCD clock with debounced MODE/INC buttons for setting hours and minutes.
// Produces the four display digits, a 1 Hz pulse and a blink flag for the field being set.
module time_keeper #(
  parameter int TICK_DIV     = 100000000,
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [1:0] hour1,
  output logic [3:0] hour0,
  output logic [2:0] min1,
  output logic [3:0] min0,
  output logic       sec_pulse,
  output logic [1:0] set_mode,
  output logic       blink
);

  localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
  localparam logic [PS_W-1:0] PS_HALF = PS_W'(TICK_DIV / 2);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    SET_H = 2'b01,
    SET_M = 2'b10
  } mode_e;

  // Button index 0 = MODE, 1 = INC
  logic [1:0]           sync1_q, sync1_d;
  logic [1:0]           sync2_q, sync2_d;
  logic [1:0]           db_lvl_q, db_lvl_d;
  logic [1:0]           press_q, press_d;
  logic [1:0][DB_W-1:0] db_cnt_q, db_cnt_d;

  logic [PS_W-1:0] ps_q, ps_d;
  logic [5:0]      sec_q, sec_d;
  logic [1:0]      h1_q, h1_d;
  logic [3:0]      h0_q, h0_d;
  logic [2:0]      m1_q, m1_d;
  logic [3:0]      m0_q, m0_d;
  mode_e           mode_q, mode_d;
  logic            sec_pulse_q, sec_pulse_d;
  logic            blink_q, blink_d;

  logic tick;
  logic mode_press;
  logic inc_press;
  logic min_at_max;
  logic min_step;
  logic hour_step;

  assign tick       = (ps_q == PS_LAST);
  assign mode_press = press_q[0];
  assign inc_press  = press_q[1];
  assign min_at_max = (m1_q == 3'd5) && (m0_q == 4'd9);

  always_comb begin
    sync1_d  = {btn_inc, btn_mode};
    sync2_d  = sync1_q;
    db_lvl_d = db_lvl_q;
    press_d  = '0;
    db_cnt_d = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_lvl_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          db_lvl_d[i] = sync2_q[i];
          press_d[i]  = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    ps_d      = tick ? '0 : ps_q + 1'b1;
    sec_d     = sec_q;
    h1_d      = h1_q;
    h0_d      = h0_q;
    m1_d      = m1_q;
    m0_d      = m0_q;
    mode_d    = mode_q;
    min_step  = 1'b0;
    hour_step = 1'b0;

    // A mode press takes priority over any INC press or tick in the same cycle
    if (mode_press) begin
      case (mode_q)
        RUN:     mode_d = SET_H;
        SET_H:   mode_d = SET_M;
        SET_M: begin
          mode_d = RUN;
          sec_d  = '0;
          ps_d   = '0;
        end
        default: mode_d = RUN;
      endcase
    end else begin
      case (mode_q)
        RUN: begin
          if (tick) begin
            if (sec_q == 6'd59) begin
              sec_d     = '0;
              min_step  = 1'b1;
              hour_step = min_at_max;
            end else begin
              sec_d = sec_q + 1'b1;
            end
          end
        end
        SET_H:   hour_step = inc_press;
        SET_M:   min_step  = inc_press;
        default: mode_d    = RUN;
      endcase
    end

    if (min_step) begin
      if (m0_q == 4'd9) begin
        m0_d = '0;
        m1_d = (m1_q == 3'd5) ? '0 : m1_q + 1'b1;
      end else begin
        m0_d = m0_q + 1'b1;
      end
    end

    if (hour_step) begin
      if ((h1_q == 2'd2) && (h0_q == 4'd3)) begin
        h1_d = '0;
        h0_d = '0;
      end else if (h0_q == 4'd9) begin
        h0_d = '0;
        h1_d = h1_q + 1'b1;
      end else begin
        h0_d = h0_q + 1'b1;
      end
    end

    sec_pulse_d = (ps_d == PS_LAST);
    blink_d     = (mode_d == RUN) || (ps_d < PS_HALF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      db_lvl_q    <= '0;
      press_q     <= '0;
      db_cnt_q    <= '0;
      ps_q        <= '0;
      sec_q       <= '0;
      h1_q        <= '0;
      h0_q        <= '0;
      m1_q        <= '0;
      m0_q        <= '0;
      mode_q      <= RUN;
      sec_pulse_q <= 1'b0;
      blink_q     <= 1'b1;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      db_lvl_q    <= db_lvl_d;
      press_q     <= press_d;
      db_cnt_q    <= db_cnt_d;
      ps_q        <= ps_d;
      sec_q       <= sec_d;
      h1_q        <= h1_d;
      h0_q        <= h0_d;
      m1_q        <= m1_d;
      m0_q        <= m0_d;
      mode_q      <= mode_d;
      sec_pulse_q <= sec_pulse_d;
      blink_q     <= blink_d;
    end
  end

  assign hour1     = h1_q;
  assign hour0     = h0_q;
  assign min1      = m1_q;
  assign min0      = m0_q;
  assign set_mode  = mode_q;
  assign sec_pulse = sec_pulse_q;
  assign blink     = blink_q;

endmodule
